sap_control_sequencer: RTL and testbench

- Fetch/decode/execute sequencer for the 16-bit SAP core.
- Steps through micro-states T0..T4 and decodes the 4-bit IR opcode.
- Issues one-hot bus-driver and register-load strobes to the PC, MAR, RAM, IR, A, B, ALU and flag register.
- Owns the `flag_write` strobe and consumes the flag register output for conditional jumps.

---
 rtl/sap_control_sequencer.sv | 160 ++++++++++++++++
 tb/tb_sap_control_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sap_control_sequencer.sv
// Fetch/decode/execute control sequencer for the 16-bit SAP core.
// Walks T0..T4 and decodes the IR opcode into one-hot bus/load strobes.
module sap_control_sequencer #(
    parameter int                 OPC_W   = 4,
    parameter logic [OPC_W-1:0]   HLT_OPC = 'hF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [OPC_W-1:0] opcode,
    input  logic [1:0]       flags,
    output logic             pc_out,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             mar_in,
    output logic             ram_out,
    output logic             ram_in,
    output logic             ir_in,
    output logic             ir_out,
    output logic             a_in,
    output logic             a_out,
    output logic             b_in,
    output logic             alu_out,
    output logic             alu_sub,
    output logic             flag_write,
    output logic             halted,
    output logic             instr_done,
    output logic [2:0]       step
);

    localparam logic [OPC_W-1:0] OP_LDA = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_STA = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_LDI = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_JC  = OPC_W'(7);
    localparam logic [OPC_W-1:0] OP_JZ  = OPC_W'(8);

    logic [2:0] step_q, step_d;
    logic       halt_q, halt_d;
    logic       run;

    // Strobes only fire while out of reset, enabled and not halted.
    assign run    = rst & ena & ~halt_q;
    assign step   = step_q;
    assign halted = halt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_q <= 3'd0;
            halt_q <= 1'b0;
        end else begin
            step_q <= step_d;
            halt_q <= halt_d;
        end
    end

    always_comb begin
        step_d = step_q;
        halt_d = halt_q;
        if (instr_done) begin
            step_d = 3'd0;
            halt_d = (opcode == HLT_OPC);
        end else if (run) begin
            step_d = (step_q >= 3'd4) ? 3'd0 : step_q + 3'd1;
        end
    end

    always_comb begin
        pc_out     = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        mar_in     = 1'b0;
        ram_out    = 1'b0;
        ram_in     = 1'b0;
        ir_in      = 1'b0;
        ir_out     = 1'b0;
        a_in       = 1'b0;
        a_out      = 1'b0;
        b_in       = 1'b0;
        alu_out    = 1'b0;
        alu_sub    = 1'b0;
        flag_write = 1'b0;
        instr_done = 1'b0;
        if (run) begin
            case (step_q)
                3'd0: begin
                    pc_out = 1'b1;
                    mar_in = 1'b1;
                end
                3'd1: begin
                    ram_out = 1'b1;
                    ir_in   = 1'b1;
                    pc_inc  = 1'b1;
                end
                3'd2: begin
                    // Flags are read live here so a just-written ADD/SUB result steers JC/JZ.
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            ir_out = 1'b1;
                            mar_in = 1'b1;
                        end
                        OP_LDI: begin
                            ir_out     = 1'b1;
                            a_in       = 1'b1;
                            instr_done = 1'b1;
                        end
                        OP_JMP: begin
                            ir_out     = 1'b1;
                            pc_load    = 1'b1;
                            instr_done = 1'b1;
                        end
                        OP_JC: begin
                            ir_out     = flags[1];
                            pc_load    = flags[1];
                            instr_done = 1'b1;
                        end
                        OP_JZ: begin
                            ir_out     = flags[0];
                            pc_load    = flags[0];
                            instr_done = 1'b1;
                        end
                        default: instr_done = 1'b1;
                    endcase
                end
                3'd3: begin
                    case (opcode)
                        OP_LDA: begin
                            ram_out    = 1'b1;
                            a_in       = 1'b1;
                            instr_done = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ram_out = 1'b1;
                            b_in    = 1'b1;
                        end
                        OP_STA: begin
                            a_out      = 1'b1;
                            ram_in     = 1'b1;
                            instr_done = 1'b1;
                        end
                        default: ;
                    endcase
                end
                3'd4: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        alu_out    = 1'b1;
                        a_in       = 1'b1;
                        flag_write = 1'b1;
                        alu_sub    = (opcode == OP_SUB);
                        instr_done = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Self-checking bench for sap_control_sequencer: vector table, corner sequences,
// then randomized run against an instruction-level reference model.
module tb_sap_control_sequencer;

    typedef logic [14:0] sv_t;
    localparam sv_t PO = 15'h4000, PI = 15'h2000, PL = 15'h1000, MI = 15'h0800;
    localparam sv_t RO = 15'h0400, RI = 15'h0200, II = 15'h0100, IO = 15'h0080;
    localparam sv_t AI = 15'h0040, AO = 15'h0020, BI = 15'h0010, EO = 15'h0008;
    localparam sv_t SU = 15'h0004, FW = 15'h0002, DN = 15'h0001;

    logic       clk = 1'b0, rst = 1'b0, ena = 1'b0;
    logic [3:0] opcode = 4'd0;
    logic [1:0] flags = 2'd0;
    logic pc_out, pc_inc, pc_load, mar_in, ram_out, ram_in, ir_in, ir_out;
    logic a_in, a_out, b_in, alu_out, alu_sub, flag_write, halted, instr_done;
    logic [2:0] step;
    sv_t act;

    int errors = 0, checks = 0;

    typedef struct {
        logic       r;
        logic       e;
        logic [3:0] o;
        logic [1:0] f;
        logic [2:0] s;
        sv_t        m;
    } vec_t;
    vec_t tbl[$];

    sv_t ucode[16][3];
    int  ulen[16];

    sap_control_sequencer dut (
        .clk(clk), .rst(rst), .ena(ena), .opcode(opcode), .flags(flags),
        .pc_out(pc_out), .pc_inc(pc_inc), .pc_load(pc_load), .mar_in(mar_in),
        .ram_out(ram_out), .ram_in(ram_in), .ir_in(ir_in), .ir_out(ir_out),
        .a_in(a_in), .a_out(a_out), .b_in(b_in), .alu_out(alu_out),
        .alu_sub(alu_sub), .flag_write(flag_write), .halted(halted),
        .instr_done(instr_done), .step(step)
    );

    assign act = {pc_out, pc_inc, pc_load, mar_in, ram_out, ram_in, ir_in, ir_out,
                  a_in, a_out, b_in, alu_out, alu_sub, flag_write, instr_done};

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic e, input logic [3:0] o,
                       input logic [1:0] f, input logic [2:0] s, input sv_t m);
        vec_t v;
        v.r = r; v.e = e; v.o = o; v.f = f; v.s = s; v.m = m;
        tbl.push_back(v);
    endtask

    task automatic add_fetch(input logic [3:0] o, input logic [1:0] f);
        add(1'b1, 1'b1, o, f, 3'd0, PO | MI);
        add(1'b1, 1'b1, o, f, 3'd1, RO | II | PI);
    endtask

    task automatic check(input string name, input sv_t m, input logic h, input logic [2:0] s);
        checks++;
        if ({act, halted, step} !== {m, h, s}) begin
            errors++;
            $display("FAIL %s: got strobes=%h halted=%b step=%0d, want strobes=%h halted=%b step=%0d",
                     name, act, halted, step, m, h, s);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic [3:0] o, input logic [1:0] f);
        @(negedge clk);
        rst = r; ena = e; opcode = o; flags = f;
        #1;
    endtask

    // Instruction-level reference: fetch is fixed, execute comes from a per-opcode micro-program.
    function automatic sv_t model_out(input logic r, input logic e, input logic [3:0] o,
                                      input logic [1:0] f, input int s, input bit h);
        sv_t m;
        if (!r || !e || h) return '0;
        if (s == 0) return PO | MI;
        if (s == 1) return RO | II | PI;
        m = ucode[o][s-2];
        if ((o == 4'd7 && !f[1]) || (o == 4'd8 && !f[0])) m = '0;
        if (s - 1 == ulen[o]) m = m | DN;
        return m;
    endfunction

    initial begin
        int  mstep;
        bit  mhalt;
        logic r, e;
        logic [3:0] cur_op;
        logic [1:0] f;
        sv_t exp_m;

        for (int o = 0; o < 16; o++) begin
            ulen[o] = 1;
            for (int k = 0; k < 3; k++) ucode[o][k] = '0;
        end
        ulen[1] = 2; ucode[1][0] = IO | MI; ucode[1][1] = RO | AI;
        ulen[2] = 3; ucode[2][0] = IO | MI; ucode[2][1] = RO | BI; ucode[2][2] = EO | AI | FW;
        ulen[3] = 3; ucode[3][0] = IO | MI; ucode[3][1] = RO | BI; ucode[3][2] = EO | AI | FW | SU;
        ulen[4] = 2; ucode[4][0] = IO | MI; ucode[4][1] = AO | RI;
        ucode[5][0] = IO | AI;
        ucode[6][0] = IO | PL;
        ucode[7][0] = IO | PL;
        ucode[8][0] = IO | PL;

        // Directed vector table: one record per cycle.
        add(1'b0, 1'b1, 4'd0, 2'd0, 3'd0, '0);
        add(1'b0, 1'b1, 4'd0, 2'd0, 3'd0, '0);
        add_fetch(4'd0, 2'd0); add(1'b1, 1'b1, 4'd0, 2'd0, 3'd2, DN);
        add_fetch(4'd2, 2'd0);
        add(1'b1, 1'b1, 4'd2, 2'd0, 3'd2, IO | MI);
        add(1'b1, 1'b1, 4'd2, 2'd0, 3'd3, RO | BI);
        add(1'b1, 1'b1, 4'd2, 2'd0, 3'd4, EO | AI | FW | DN);
        add_fetch(4'd3, 2'd0);
        add(1'b1, 1'b1, 4'd3, 2'd0, 3'd2, IO | MI);
        add(1'b1, 1'b1, 4'd3, 2'd0, 3'd3, RO | BI);
        add(1'b1, 1'b1, 4'd3, 2'd0, 3'd4, EO | AI | FW | SU | DN);
        add_fetch(4'd7, 2'b10); add(1'b1, 1'b1, 4'd7, 2'b10, 3'd2, IO | PL | DN);
        add_fetch(4'd7, 2'b00); add(1'b1, 1'b1, 4'd7, 2'b00, 3'd2, DN);
        add_fetch(4'd8, 2'b01); add(1'b1, 1'b1, 4'd8, 2'b01, 3'd2, IO | PL | DN);
        add_fetch(4'd8, 2'b10); add(1'b1, 1'b1, 4'd8, 2'b10, 3'd2, DN);
        add_fetch(4'd5, 2'd0); add(1'b1, 1'b1, 4'd5, 2'd0, 3'd2, IO | AI | DN);
        add_fetch(4'd4, 2'd0);
        add(1'b1, 1'b1, 4'd4, 2'd0, 3'd2, IO | MI);
        add(1'b1, 1'b1, 4'd4, 2'd0, 3'd3, AO | RI | DN);
        add_fetch(4'd6, 2'd0); add(1'b1, 1'b1, 4'd6, 2'd0, 3'd2, IO | PL | DN);
        add_fetch(4'hA, 2'd3); add(1'b1, 1'b1, 4'hA, 2'd3, 3'd2, DN);

        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].e, tbl[i].o, tbl[i].f);
            check($sformatf("tbl[%0d]", i), tbl[i].m, 1'b0, tbl[i].s);
        end

        // HLT: machine parks with every strobe low whatever ena/opcode do.
        drive(1'b1, 1'b1, 4'hF, 2'd0); check("hlt_t0", PO | MI, 1'b0, 3'd0);
        drive(1'b1, 1'b1, 4'hF, 2'd0); check("hlt_t1", RO | II | PI, 1'b0, 3'd1);
        drive(1'b1, 1'b1, 4'hF, 2'd0); check("hlt_t2", DN, 1'b0, 3'd2);
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'($urandom), 4'($urandom), 2'($urandom));
            check("halted_idle", '0, 1'b1, 3'd0);
        end
        @(negedge clk); #2 rst = 1'b0; #1;
        check("halt_async_clear", '0, 1'b0, 3'd0);

        // LDA with ena dropped at T3: step holds, T3 strobes fire once on resume.
        drive(1'b1, 1'b1, 4'd1, 2'd0); check("lda_t0", PO | MI, 1'b0, 3'd0);
        drive(1'b1, 1'b1, 4'd1, 2'd0); check("lda_t1", RO | II | PI, 1'b0, 3'd1);
        drive(1'b1, 1'b1, 4'd1, 2'd0); check("lda_t2", IO | MI, 1'b0, 3'd2);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 4'd1, 2'd0); check("lda_frozen", '0, 1'b0, 3'd3);
        end
        drive(1'b1, 1'b1, 4'd1, 2'd0); check("lda_t3", RO | AI | DN, 1'b0, 3'd3);

        // ADD interrupted by reset in T3: no flag_write, restart from T0.
        drive(1'b1, 1'b1, 4'd2, 2'd0); check("add_t0", PO | MI, 1'b0, 3'd0);
        drive(1'b1, 1'b1, 4'd2, 2'd0); check("add_t1", RO | II | PI, 1'b0, 3'd1);
        drive(1'b1, 1'b1, 4'd2, 2'd0); check("add_t2", IO | MI, 1'b0, 3'd2);
        drive(1'b1, 1'b1, 4'd2, 2'd0); check("add_t3", RO | BI, 1'b0, 3'd3);
        #2 rst = 1'b0; #1;
        check("add_rst_drop", '0, 1'b0, 3'd0);
        drive(1'b0, 1'b1, 4'd2, 2'd0); check("add_rst_hold", '0, 1'b0, 3'd0);
        drive(1'b1, 1'b1, 4'd2, 2'd0); check("add_restart_t0", PO | MI, 1'b0, 3'd0);
        drive(1'b1, 1'b1, 4'd2, 2'd0); check("add_restart_t1", RO | II | PI, 1'b0, 3'd1);

        // Randomized run against the reference model; opcode held per instruction.
        mstep = 0; mhalt = 0; cur_op = 4'd0;
        for (int i = 0; i < 800; i++) begin
            r = (i == 0) ? 1'b0 : ($urandom_range(0, 99) >= 3);
            e = ($urandom_range(0, 99) < 80);
            f = 2'($urandom);
            if (!r) begin
                mstep = 0;
                mhalt = 0;
            end
            if (mstep == 0) cur_op = 4'($urandom);
            drive(r, e, cur_op, f);
            exp_m = model_out(r, e, cur_op, f, mstep, mhalt);
            check("random", exp_m, mhalt, 3'(mstep));
            if (r && e && !mhalt) begin
                if (exp_m[0]) begin
                    mstep = 0;
                    if (cur_op == 4'hF) mhalt = 1;
                end else begin
                    mstep++;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
